mem_data_arbiter: RTL and testbench
===================================

# mem_data_arbiter

Two-requester arbiter and sequencer for the data port (port 2) of the CPU's byte-addressed unified memory. Requester 0 is the CPU load/store path; requester 1 is a secondary master (debug loader / DMA). The block accepts one transaction at a time, drives the memory data-port controls for exactly one cycle, and returns the registered read data and the misalignment or out-of-range error flag to the winner. The instruction port (port 1) bypasses this block.

## Interface
- NUM_W, 32, address and data width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- mN_req  in  1  requester N (N=0,1) transaction request; held until mN_gnt
- mN_we  in  1  1 = store, 0 = load
- mN_addr  in  32  byte address
- mN_wdata  in  32  store data, right-justified
- mN_size  in  2  00 byte, 01 half, 10 word
- mN_sign  in  1  1 = unsigned load, 0 = signed
- mN_gnt  out  1  one-cycle pulse; request fields sampled this cycle
- mN_rvalid  out  1  one-cycle completion pulse (loads and stores)
- mN_rdata  out  32  load data, valid with mN_rvalid; 0 for stores or errors
- mN_err  out  1  error flag, valid with mN_rvalid
- mem_rd  out  1  to memory data-port read enable
- mem_wr  out  1  to memory write enable
- mem_addr  out  32  to memory data-port address
- mem_wdata  out  32  to memory write data
- mem_size  out  2  to memory size
- mem_sign  out  1  to memory sign
- mem_rdata  in  32  memory data-port registered read data
- mem_err  in  1  memory combinational error flag

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset and default state: IDLE.
- IDLE: if any mN_req, pick a winner, pulse its mN_gnt, and latch we/addr/wdata/size/sign plus the owner ID into the request register. Go to ISSUE. Otherwise stay.
- ISSUE, one cycle: drive mem_* from the request register. mem_rd = !we and mem_wr = we. Sample mem_err into the err register. Go to RESP.
- RESP, one cycle: pulse the owner's mN_rvalid. rdata = mem_rdata if load and !err, else 0. err = sampled err. Return to IDLE.
- Outside ISSUE: mem_rd = mem_wr = 0. mem_addr/wdata/size/sign hold the request register.
- Error: the memory already suppresses access when it flags an error. The arbiter only reports it and never retries.
- Requester rules:
  - Fields must be stable while mN_req=1 and mN_gnt=0.
  - After gnt, fields may change.
  - A new req may be raised before rvalid, but it is not granted until the FSM is back in IDLE.
- Non-winner req stays pending and receives no gnt.
- Outputs not owned by the current transaction stay 0.

## Timing
- Request seen in IDLE at cycle T: gnt at T, mem strobe at T+1, rvalid/rdata/err at T+2. Next grant is possible at T+3.
- Throughput is one transaction per 3 cycles. Read latency matches the memory's one-cycle registered read.
- Simultaneous req from both requesters: exactly one gnt. The arbitration rule is under Configuration.
- Reset (rst_n=0 at any edge, including mid-ISSUE or mid-RESP):
  - State forced to IDLE.
  - All outputs 0 in the following cycle.
  - The RR pointer is reset.
  - No pending rvalid is emitted.
  - A write strobed in the same cycle as reset assertion is not guaranteed to be blocked.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: round-robin arbitration.
  - A one-bit last-winner pointer is updated on every grant and reset to 1, so requester 0 wins the first contention.
  - On simultaneous requests, the requester that is not the last winner is granted.
- Undefined: fixed priority, requester 0 always wins. No pointer register exists.

## Structure
- Shared package mem_pkg holds:
  - size enum (BYTE=2'b00, HALF=2'b01, WORD=2'b10)
  - sign enum (SIGNED=0, UNSIGNED=1)
  - arbiter state enum (IDLE, ISSUE, RESP)
  - packed request struct {we, addr, wdata, size, sign}
- One sub-module, mem_arb_pick: combinational 2-way winner select plus the optional pointer flop, with the pointer wrapped in the macro.

## Test plan
- Single load: m0 lw at 0x100 with mem word 0xDEADBEEF. Expect m0_gnt at T, mem_rd=1 only at T+1, m0_rvalid at T+2 with rdata 0xDEADBEEF and err=0.
- Store then load: m1 sw 0x12345678 to 0x200, then m1 lbu at 0x203. Expect the store rvalid with rdata=0, then load rdata=0x00000012.
- Error: m0 lh at 0x101. Expect mem_err sampled, m0_rvalid with err=1 and rdata=0, and the memory word unchanged.
- Contention: m0 and m1 req held continuously for 4 transactions.
  - With the macro: grant order 0,1,0,1.
  - Without it: 0,0,0,0, with m1 never granted.
- Reset mid-operation: rst_n=0 in ISSUE. Expect no rvalid, state IDLE, all outputs 0 next cycle, and the next request completing normally with 3-cycle latency.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types for the memory data-port arbiter
// Purpose : access size/sign encodings, arbiter state encoding and the packed
//           request record latched at grant time.
// Ports   : none (package).
package mem_pkg;

  localparam int NUM_W = 32;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_e;

  typedef enum logic {
    SIGNED   = 1'b0,
    UNSIGNED = 1'b1
  } mem_sign_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_e;

  typedef struct packed {
    logic             we;
    logic [NUM_W-1:0] addr;
    logic [NUM_W-1:0] wdata;
    mem_size_e        size;
    mem_sign_e        sign;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - two-way winner select for the data-port arbiter
// Purpose : combinational choice between requester 0 and 1.
//           MEM_ARB_ROUND_ROBIN_EN defined : round robin with a one-bit
//             last-winner pointer (reset to 1 so requester 0 wins first).
//           MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 wins;
//             no pointer flop and no clock/reset/take ports.
// Ports   : clk, rst_n, take (RR build only) - clock, sync active-low reset,
//             grant-taken strobe that updates the pointer
//           req0, req1 - pending requests
//           sel        - winner id (valid when any=1)
//           any        - at least one request pending
module mem_arb_pick
  import mem_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic clk,
  input  logic rst_n,
  input  logic take,
`endif
  input  logic req0,
  input  logic req1,
  output logic sel,
  output logic any
);

  assign any = req0 | req1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (take) begin
      last <= sel;
    end
  end

  // On contention the requester that did not win last time goes next.
  assign sel = (req0 && req1) ? ~last : req1;
`else
  assign sel = req1 & ~req0;
`endif

endmodule

// File: rtl/mem_data_arbiter.sv
// rtl/mem_data_arbiter.sv - two-requester arbiter/sequencer for memory data port 2
// Purpose : accepts one transaction at a time, strobes the memory for exactly
//           one cycle and returns registered read data / error to the owner.
//           Grant at T, memory strobe at T+1, rvalid/rdata/err at T+2.
//           Arbitration mode selected by MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick).
// Ports   : clk, rst_n                 - clock, sync active-low reset
//           mN_req/we/addr/wdata/size/sign (N=0,1) - requester fields
//           mN_gnt, mN_rvalid, mN_rdata, mN_err    - requester responses
//           mem_rd/wr/addr/wdata/size/sign         - memory data-port controls
//           mem_rdata, mem_err         - memory registered read data, comb error
module mem_data_arbiter
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [NUM_W-1:0] m0_addr,
  input  logic [NUM_W-1:0] m0_wdata,
  input  logic [1:0]       m0_size,
  input  logic             m0_sign,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [NUM_W-1:0] m0_rdata,
  output logic             m0_err,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [NUM_W-1:0] m1_addr,
  input  logic [NUM_W-1:0] m1_wdata,
  input  logic [1:0]       m1_size,
  input  logic             m1_sign,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [NUM_W-1:0] m1_rdata,
  output logic             m1_err,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [NUM_W-1:0] mem_addr,
  output logic [NUM_W-1:0] mem_wdata,
  output logic [1:0]       mem_size,
  output logic             mem_sign,
  input  logic [NUM_W-1:0] mem_rdata,
  input  logic             mem_err
);

  arb_state_e state;
  mem_req_t   req_q;
  mem_req_t   win;
  logic       owner;
  logic       err_q;
  logic       sel;
  logic       any;
  logic       take;

  mem_arb_pick u_pick (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .clk  (clk),
    .rst_n(rst_n),
    .take (take),
`endif
    .req0 (m0_req),
    .req1 (m1_req),
    .sel  (sel),
    .any  (any)
  );

  // Grant is combinational so the requester sees it in the cycle its request
  // is first seen in IDLE; it is held off while reset is asserted.
  assign take   = rst_n && (state == IDLE) && any;
  assign m0_gnt = take && !sel;
  assign m1_gnt = take &&  sel;

  assign win = sel ? {m1_we, m1_addr, m1_wdata, m1_size, m1_sign}
                   : {m0_we, m0_addr, m0_wdata, m0_size, m0_sign};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_q     <= '0;
      owner     <= 1'b0;
      err_q     <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            req_q  <= win;
            owner  <= sel;
            mem_rd <= !win.we;
            mem_wr <=  win.we;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          err_q     <= mem_err;
          mem_rd    <= 1'b0;
          mem_wr    <= 1'b0;
          m0_rvalid <= !owner;
          m1_rvalid <=  owner;
          state     <= RESP;
        end
        RESP: begin
          m0_rvalid <= 1'b0;
          m1_rvalid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_size  = req_q.size;
  assign mem_sign  = req_q.sign;

  // Memory read data is already registered, so it is forwarded during RESP.
  assign m0_rdata = (m0_rvalid && !req_q.we && !err_q) ? mem_rdata : '0;
  assign m1_rdata = (m1_rvalid && !req_q.we && !err_q) ? mem_rdata : '0;
  assign m0_err   = m0_rvalid && err_q;
  assign m1_err   = m1_rvalid && err_q;

endmodule

// File: tb/tb_mem_data_arbiter.sv
// tb/tb_mem_data_arbiter.sv - self-checking bench for mem_data_arbiter
module tb_mem_data_arbiter;
  import mem_pkg::*;

  localparam int MEM_BYTES = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        m0_req, m0_we, m0_sign, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [1:0]  m0_size;
  logic        m1_req, m1_we, m1_sign, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [1:0]  m1_size;
  logic        mem_rd, mem_wr, mem_sign, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;

  mem_data_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_size(m0_size), .m0_sign(m0_sign), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_size(m1_size), .m1_sign(m1_sign), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_sign(mem_sign), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int ref_last = 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic bad_access(input logic [31:0] a, input logic [1:0] sz);
    return (a >= 32'(MEM_BYTES)) || (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
           (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] sz, input logic uns);
    case (sz)
      2'b00:   return uns ? {24'h0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
      2'b01:   return uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic logic [7:0] fill_byte(input int i);
    logic [31:0] w;
    w = 32'hDEADBEEF;
    if (i >= 256 && i < 260) return w[8*(i-256) +: 8];
    return 8'(i * 7 + 3);
  endfunction

  // Environment memory: byte array, combinational error, registered read.
  logic [7:0]  mem_bytes [MEM_BYTES];
  logic        mem_fill;
  logic [11:0] ma;
  assign ma      = mem_addr[11:0];
  assign mem_err = bad_access(mem_addr, mem_size);

  always @(posedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < MEM_BYTES; i++) mem_bytes[i] <= fill_byte(i);
    end else begin
      if (mem_wr && !mem_err) begin
        mem_bytes[ma] <= mem_wdata[7:0];
        if (mem_size != 2'b00) mem_bytes[ma + 12'd1] <= mem_wdata[15:8];
        if (mem_size == 2'b10) begin
          mem_bytes[ma + 12'd2] <= mem_wdata[23:16];
          mem_bytes[ma + 12'd3] <= mem_wdata[31:24];
        end
      end
      if (mem_rd && !mem_err)
        mem_rdata <= extend({mem_bytes[ma + 12'd3], mem_bytes[ma + 12'd2],
                             mem_bytes[ma + 12'd1], mem_bytes[ma]}, mem_size, mem_sign);
    end
  end

  // Reference shadow of memory contents, updated per completed transaction.
  logic [7:0] ref_mem [MEM_BYTES];

  task automatic drive(input int id, input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns);
    if (id == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_size = size; m0_sign = uns;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_size = size; m1_sign = uns;
    end
  endtask

  // One isolated transaction: starts on an IDLE cycle, ends inside RESP.
  task automatic do_txn(input int id, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic uns);
    logic        exp_err;
    logic [31:0] exp_data, raw, got_rdata;
    logic [11:0] a;
    logic        got_gnt, oth_gnt, got_err;
    a        = addr[11:0];
    exp_err  = bad_access(addr, size);
    raw      = {ref_mem[a + 12'd3], ref_mem[a + 12'd2], ref_mem[a + 12'd1], ref_mem[a]};
    exp_data = (!we && !exp_err) ? extend(raw, size, uns) : 32'h0;
    @(negedge clk);
    drive(id, 1'b1, we, addr, wdata, size, uns);
    #1;
    got_gnt = (id == 0) ? m0_gnt : m1_gnt;
    oth_gnt = (id == 0) ? m1_gnt : m0_gnt;
    check("gnt_T", 32'(got_gnt), 32'(1));
    check("gnt_other_T", 32'(oth_gnt), 0);
    check("strobe_T", 32'({mem_rd, mem_wr}), 0);
    @(negedge clk);
    drive(id, 1'b0, $urandom, $urandom, $urandom, 2'($urandom), $urandom);
    #1;
    check("strobe_T1", 32'({mem_rd, mem_wr}), 32'({!we, we}));
    check("addr_T1", mem_addr, addr);
    check("rvalid_T1", 32'({m0_rvalid, m1_rvalid}), 0);
    @(negedge clk);
    #1;
    got_rdata = (id == 0) ? m0_rdata : m1_rdata;
    got_err   = (id == 0) ? m0_err : m1_err;
    check("rvalid_T2", 32'({m0_rvalid, m1_rvalid}), (id == 0) ? 32'd2 : 32'd1);
    check("rdata_T2", got_rdata, exp_data);
    check("err_T2", 32'(got_err), 32'(exp_err));
    check("strobe_T2", 32'({mem_rd, mem_wr}), 0);
    if (we && !exp_err) begin
      ref_mem[a] = wdata[7:0];
      if (size != 2'b00) ref_mem[a + 12'd1] = wdata[15:8];
      if (size == 2'b10) begin
        ref_mem[a + 12'd2] = wdata[23:16];
        ref_mem[a + 12'd3] = wdata[31:24];
      end
    end
    ref_last = id;
  endtask

  function automatic logic any_output();
    return |{m0_gnt, m0_rvalid, m0_rdata, m0_err, m1_gnt, m1_rvalid, m1_rdata, m1_err,
             mem_rd, mem_wr, mem_addr, mem_wdata, mem_size, mem_sign};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a32;
    int          w, exp_w;
    rst_n    = 1'b0;
    mem_fill = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = fill_byte(i);
    repeat (2) @(negedge clk);
    mem_fill = 1'b0;
    #1;
    check("reset_outputs", 32'(any_output()), 0);
    rst_n = 1'b1;

    // Directed: word load, store then byte load, misaligned half load.
    do_txn(0, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0);
    do_txn(1, 1'b1, 32'h200, 32'h12345678, 2'b10, 1'b0);
    do_txn(1, 1'b0, 32'h203, 32'h0, 2'b00, 1'b1);
    do_txn(0, 1'b0, 32'h101, 32'h0, 2'b01, 1'b0);
    check("err_mem_unchanged", {mem_bytes[259], mem_bytes[258], mem_bytes[257], mem_bytes[256]},
          32'hDEADBEEF);

    // Randomized single-requester transactions.
    for (int k = 0; k < 24; k++) begin
      a32 = ($urandom_range(0, 7) == 0) ? 32'h10000 + $urandom_range(0, 255)
                                        : 32'($urandom_range(0, MEM_BYTES - 1));
      do_txn(int'($urandom_range(0, 1)), 1'($urandom), a32, $urandom,
             2'($urandom_range(0, 2)), 1'($urandom));
    end

    // Reset while the strobe is on the memory port.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0);
    #1;
    check("rst_gnt", 32'(m0_gnt), 32'(1));
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_issue_rd", 32'(mem_rd), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_outputs_zero", 32'(any_output()), 0);
    ref_last = 1;
    @(negedge clk);
    #1;
    check("rst_no_rvalid", 32'({m0_rvalid, m1_rvalid}), 0);
    do_txn(1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b1);
    ref_last = 1;
    // Pointer back to its reset value before contention (RR build).
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Contention: both requests held for four grants.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0);
    drive(1, 1'b1, 1'b0, 32'h200, 32'h0, 2'b10, 1'b0);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      w = 0;
      while (!(m0_gnt || m1_gnt) && w < 5) begin
        @(negedge clk);
        #1;
        w++;
      end
      check("cont_gnt_seen", 32'(m0_gnt | m1_gnt), 32'(1));
      check("cont_onehot", 32'(m0_gnt & m1_gnt), 0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_w = (ref_last == 1) ? 0 : 1;
`else
      exp_w = 0;
`endif
      check("cont_winner", 32'(m1_gnt), 32'(exp_w));
      ref_last = exp_w;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("cont_rvalid", 32'({m0_rvalid, m1_rvalid}), (exp_w == 0) ? 32'd2 : 32'd1);
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    @(negedge clk);
    #1;
    check("idle_after_cont", 32'(m0_gnt | m1_gnt | mem_rd | mem_wr), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
